// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch port and the LSU, one access at a time.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration (fixed LSU-over-fetch otherwise).
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RSP_TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [3:0]        lsu_be_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  output logic              lsu_gnt_o,
  output logic              lsu_rvalid_o,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  localparam int CNT_W = $clog2(RSP_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic                r_ownerLsu;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err;
  logic                r_we;
  logic [3:0]          r_be;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                w_winLsu;
  logic                w_grant;
  logic                w_timeout;
  logic                w_done;

`ifdef MEM_ARB_RR_EN
  logic r_lastLsu;

  // Under contention the port that was not served last wins.
  always_comb begin
    w_winLsu = lsu_req_i;
    if (lsu_req_i && if_req_i) begin
      w_winLsu = !r_lastLsu;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lastLsu <= 1'b1;
    end else if (w_grant) begin
      r_lastLsu <= w_winLsu;
    end
  end
`else
  assign w_winLsu = lsu_req_i;
`endif

  assign w_timeout = (r_state == RESP) && (r_cnt == CNT_W'(RSP_TIMEOUT));
  assign w_done    = (r_state == RESP) && (mem_rvalid_i || w_timeout);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_grant      = 1'b0;
    mem_req_o    = 1'b0;
    if_gnt_o     = 1'b0;
    lsu_gnt_o    = 1'b0;
    if_rvalid_o  = 1'b0;
    lsu_rvalid_o = 1'b0;
    if_rdata_o   = '0;
    lsu_rdata_o  = '0;
    case (r_state)
      IDLE: begin
        if (if_req_i || lsu_req_i) begin
          w_grant     = 1'b1;
          if_gnt_o    = !w_winLsu;
          lsu_gnt_o   = w_winLsu;
          w_nextState = REQ;
        end
      end
      REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) begin
          w_nextState = RESP;
        end
      end
      RESP: begin
        // A real response beats a simultaneous watchdog expiry; a forced completion returns zero data.
        if (w_done) begin
          w_nextState = IDLE;
          if (r_ownerLsu) begin
            lsu_rvalid_o = 1'b1;
            lsu_rdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
          end else begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ownerLsu <= 1'b0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else if (w_grant) begin
      r_ownerLsu <= w_winLsu;
      r_we       <= w_winLsu ? lsu_we_i : 1'b0;
      r_be       <= w_winLsu ? lsu_be_i : 4'hF;
      r_addr     <= w_winLsu ? lsu_addr_i : if_addr_i;
      r_wdata    <= w_winLsu ? lsu_wdata_i : '0;
    end
  end

  // The watchdog counts cycles spent in RESP and is held at zero elsewhere.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (r_state == RESP) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_timeout && !mem_rvalid_i) begin
      r_err <= 1'b1;
    end
  end

  assign mem_we_o    = r_we;
  assign mem_be_o    = r_be;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign err_o       = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized transaction-level check of mem_arbiter against a timing/priority model.
// Honours MEM_ARB_RR_EN to pick the expected arbitration rule.
module tb_mem_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [3:0]  lsu_be_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_gnt_o;
  logic        lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RSP_TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Requester-side model: pending requests with the fields they hold until granted.
  bit          ifPend  = 1'b0;
  bit          lsuPend = 1'b0;
  logic [31:0] ifAddr;
  logic        lsuWe;
  logic [3:0]  lsuBe;
  logic [31:0] lsuAddr;
  logic [31:0] lsuWdata;
  bit          lastLsu = 1'b1;
  bit          errExp  = 1'b0;
  logic        expWe;
  logic [3:0]  expBe;
  logic [31:0] expAddr;
  logic [31:0] expWdata;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic checkCycle(input string tag, input bit eIfGnt, input bit eLsuGnt, input bit eMemReq,
                            input bit eIfRv, input logic [31:0] eIfRd, input bit eLsuRv, input logic [31:0] eLsuRd);
    checkOutput({tag, ".if_gnt"}, 64'(if_gnt_o), 64'(eIfGnt));
    checkOutput({tag, ".lsu_gnt"}, 64'(lsu_gnt_o), 64'(eLsuGnt));
    checkOutput({tag, ".mem_req"}, 64'(mem_req_o), 64'(eMemReq));
    checkOutput({tag, ".if_rvalid"}, 64'(if_rvalid_o), 64'(eIfRv));
    checkOutput({tag, ".if_rdata"}, 64'(if_rdata_o), 64'(eIfRd));
    checkOutput({tag, ".lsu_rvalid"}, 64'(lsu_rvalid_o), 64'(eLsuRv));
    checkOutput({tag, ".lsu_rdata"}, 64'(lsu_rdata_o), 64'(eLsuRd));
    checkOutput({tag, ".err"}, 64'(err_o), 64'(errExp));
  endtask

  task automatic checkFields(input string tag);
    checkOutput({tag, ".mem_we"}, 64'(mem_we_o), 64'(expWe));
    checkOutput({tag, ".mem_be"}, 64'(mem_be_o), 64'(expBe));
    checkOutput({tag, ".mem_addr"}, 64'(mem_addr_o), 64'(expAddr));
    checkOutput({tag, ".mem_wdata"}, 64'(mem_wdata_o), 64'(expWdata));
  endtask

  // Pending requesters hold req and fields; idle ones drive junk fields that must be ignored.
  task automatic driveReqs();
    if_req_i    = ifPend;
    if_addr_i   = ifPend ? ifAddr : 32'($urandom);
    lsu_req_i   = lsuPend;
    lsu_we_i    = lsuPend ? lsuWe : 1'($urandom);
    lsu_be_i    = lsuPend ? lsuBe : 4'($urandom);
    lsu_addr_i  = lsuPend ? lsuAddr : 32'($urandom);
    lsu_wdata_i = lsuPend ? lsuWdata : 32'($urandom);
  endtask

  // One arbitration slot: grant cycle, gntDelay stall cycles in REQ, then the response phase.
  task automatic applyStimulus(input bit newIf, input bit newLsu, input int gntDelay,
                               input int rspDelay, input bit noRsp, input logic [31:0] rspData);
    bit winLsu;
    int limit;
    if (newIf && !ifPend) begin
      ifPend = 1'b1;
      ifAddr = 32'($urandom);
    end
    if (newLsu && !lsuPend) begin
      lsuPend  = 1'b1;
      lsuWe    = 1'($urandom);
      lsuBe    = 4'($urandom);
      lsuAddr  = 32'($urandom);
      lsuWdata = 32'($urandom);
    end
    @(negedge clk_i);
    driveReqs();
    mem_gnt_i    = 1'($urandom);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'($urandom);
    #1;
    if (!ifPend && !lsuPend) begin
      checkCycle("idle", 0, 0, 0, 0, 32'h0, 0, 32'h0);
      return;
    end
`ifdef MEM_ARB_RR_EN
    winLsu = lsuPend && (!ifPend || !lastLsu);
`else
    winLsu = lsuPend;
`endif
    checkCycle("grant", !winLsu, winLsu, 0, 0, 32'h0, 0, 32'h0);
    expWe    = winLsu ? lsuWe : 1'b0;
    expBe    = winLsu ? lsuBe : 4'hF;
    expAddr  = winLsu ? lsuAddr : ifAddr;
    expWdata = winLsu ? lsuWdata : 32'h0;
    lastLsu  = winLsu;
    if (winLsu) lsuPend = 1'b0;
    else        ifPend  = 1'b0;

    for (int k = 0; k <= gntDelay; k++) begin
      @(negedge clk_i);
      driveReqs();
      mem_gnt_i    = (k == gntDelay);
      mem_rvalid_i = 1'($urandom);
      mem_rdata_i  = 32'($urandom);
      #1;
      checkCycle("req", 0, 0, 1, 0, 32'h0, 0, 32'h0);
      checkFields("req");
    end

    limit = noRsp ? TIMEOUT : rspDelay;
    for (int j = 0; j <= limit; j++) begin
      logic [31:0] eData;
      bit done;
      @(negedge clk_i);
      driveReqs();
      mem_gnt_i    = 1'($urandom);
      mem_rvalid_i = !noRsp && (j == rspDelay);
      mem_rdata_i  = (j == limit) ? rspData : 32'($urandom);
      done  = (j == limit);
      eData = (done && !noRsp) ? rspData : 32'h0;
      #1;
      checkCycle("resp", 0, 0, 0, done && !winLsu, winLsu ? 32'h0 : eData,
                 done && winLsu, winLsu ? eData : 32'h0);
    end
    if (noRsp) errExp = 1'b1;
  endtask

  task automatic resetInReq();
    while (ifPend || lsuPend) applyStimulus(0, 0, 0, 0, 0, 32'($urandom));
    @(negedge clk_i);
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_1234;
    lsu_req_i = 1'b0;
    mem_gnt_i = 1'b0;
    #1;
    checkOutput("rst.grant", 64'(if_gnt_o), 64'd1);
    @(negedge clk_i);
    if_req_i = 1'b0;
    #1;
    checkOutput("rst.in_req", 64'(mem_req_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    errExp  = 1'b0;
    lastLsu = 1'b1;
    checkCycle("rst.async", 0, 0, 0, 0, 32'h0, 0, 32'h0);
    checkOutput("rst.mem_addr", 64'(mem_addr_o), 64'h0);
    @(negedge clk_i);
    mem_rvalid_i = 1'b1;
    #1;
    checkCycle("rst.held", 0, 0, 0, 0, 32'h0, 0, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    ifPend = 1'b1;
    ifAddr = 32'h0000_0080;
    applyStimulus(0, 0, 0, 0, 0, 32'hCAFE_0001);
  endtask

  initial begin
    rst_ni       = 1'b0;
    if_req_i     = 1'b0;
    if_addr_i    = 32'h0;
    lsu_req_i    = 1'b0;
    lsu_we_i     = 1'b0;
    lsu_be_i     = 4'h0;
    lsu_addr_i   = 32'h0;
    lsu_wdata_i  = 32'h0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hA5A5_5A5A;
    #1;
    checkCycle("reset", 0, 0, 0, 0, 32'h0, 0, 32'h0);
    errExp = 1'b0;
    checkFields("reset_fields_zero_we");
    // Reset field values are all zero, not the fetch defaults.
    checkOutput("reset.mem_be", 64'(mem_be_o), 64'h0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    $display("[TB] fetch only");
    ifPend = 1'b1;
    ifAddr = 32'h0000_0040;
    applyStimulus(0, 0, 0, 0, 0, 32'h0000_0013);

    $display("[TB] store with stall");
    lsuPend  = 1'b1;
    lsuWe    = 1'b1;
    lsuBe    = 4'b0011;
    lsuAddr  = 32'h0000_7000;
    lsuWdata = 32'hDEAD_BEEF;
    applyStimulus(0, 0, 4, 1, 0, 32'h0);

    $display("[TB] contention");
    for (int n = 0; n < 4; n++) applyStimulus(1, 1, 0, 0, 0, 32'($urandom));

    $display("[TB] timeout");
    applyStimulus(0, 1, 1, 0, 1, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 32'($urandom));

    $display("[TB] random traffic");
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 9);
      applyStimulus(1'($urandom), 1'($urandom), $urandom_range(0, 3),
                    (r == 1) ? TIMEOUT : $urandom_range(0, 3), r == 0, 32'($urandom));
    end

    $display("[TB] reset during REQ");
    resetInReq();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one unified single-port memory between the CPU instruction-fetch port and the load/store unit. It sits between the core (fetch path and LSU) and the memory/peripheral fabric. It serialises accesses with one outstanding transaction at a time, using a req/gnt/rvalid handshake on every side. A response watchdog flags hung accesses.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- RSP_TIMEOUT, 16, cycles in RESP without mem_rvalid_i before forced completion (≥2)

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch request (read only)
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid_o  out  1  fetch data valid (1-cycle pulse)
- if_rdata_o  out  DATA_W  fetch read data
- lsu_req_i  in  1  load/store request
- lsu_we_i  in  1  1 = store
- lsu_be_i  in  4  byte enables
- lsu_addr_i  in  ADDR_W  load/store address
- lsu_wdata_i  in  DATA_W  store data
- lsu_gnt_o  out  1  LSU request accepted (1-cycle pulse)
- lsu_rvalid_o  out  1  LSU completion/load data valid (pulse; also acks stores)
- lsu_rdata_o  out  DATA_W  load data
- mem_req_o  out  1  memory request
- mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  out  1/4/ADDR_W/DATA_W  held request fields
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid (reads and writes)
- mem_rdata_i  in  DATA_W  memory read data
- err_o  out  1  sticky watchdog-timeout flag

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: if any *_req_i high, select winner combinationally and assert that port's *_gnt_o in the same cycle. Latch the winner's fields and owner ID (fetch: we=0, be=4'hF, wdata=0). Next state is REQ.
- REQ: mem_req_o=1 with latched fields, held stable. On mem_gnt_i, go to RESP. Otherwise stay in REQ indefinitely; no timeout applies here.
- RESP: on mem_rvalid_i, pulse the owner's *_rvalid_o with *_rdata_o = mem_rdata_i. Both are combinational pass-through. Next state is IDLE.
- Non-owner rvalid_o stays 0. Both rdata_o outputs are 0 whenever their rvalid_o is 0.
- Watchdog: counter clears on entry to RESP and increments each RESP cycle. When it reaches RSP_TIMEOUT, it forces owner rvalid with rdata = 0, sets err_o, and returns to IDLE. err_o clears only on reset.
- mem_rvalid_i outside RESP is ignored.
- A late mem_rvalid_i after a timeout is ignored.
- Default priority is fixed: LSU beats fetch when both request in IDLE.
- Requesters hold req and fields until gnt. Fields are captured only at gnt, so later changes have no effect on the transaction.

## Timing
- Reset: state IDLE, counter 0, err_o 0. All *_gnt_o, *_rvalid_o, mem_req_o are 0. mem_* fields and rdata outputs are 0.
- Minimum transaction, with mem_gnt_i and mem_rvalid_i at their first opportunity:
  - cycle 0: req seen, gnt_o=1
  - cycle 1: mem_req_o=1, mem_gnt_i=1
  - cycle 2: mem_rvalid_i, rvalid_o=1
  - Total 3 cycles. The next gnt is possible at cycle 3 earliest.
- Throughput is at most one transaction per 3 cycles.
- Reset asserted mid-transaction: immediate return to reset values. No rvalid is issued for the aborted access, and mem_req_o drops asynchronously.
- Simultaneous mem_rvalid_i and watchdog expiry in the same cycle: the real response wins and err_o is not set.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - A last-owner register updates at each gnt. Its reset value is LSU, so fetch wins the first contention.
  - On contention, the port not served last wins. A lone requester always wins.
- MEM_ARB_RR_EN undefined: fixed LSU-over-fetch priority. No last-owner register is built.

## Test plan
- Fetch only: if_req_i=1, if_addr_i=32'h0000_0040; memory grants at once and returns 32'h0000_0013 next cycle. Required: if_gnt_o in cycle 0, mem_addr_o=32'h40, mem_be_o=4'hF, mem_we_o=0 in cycle 1, if_rvalid_o with if_rdata_o=32'h13 in cycle 2.
- Store with stall: lsu_we_i=1, lsu_be_i=4'b0011, lsu_addr_i=32'h7000, lsu_wdata_i=32'hDEAD_BEEF; mem_gnt_i delayed 4 cycles. Required: mem_* fields stable for all 5 REQ cycles, then lsu_rvalid_o on mem_rvalid_i.
- Contention, both requests high every IDLE for 4 transactions:
  - macro off: all 4 grants go to LSU.
  - MEM_ARB_RR_EN: grants alternate fetch, LSU, fetch, LSU.
- Timeout: grant given, mem_rvalid_i never asserted, RSP_TIMEOUT=16. Required: owner rvalid with rdata 0 exactly 16 cycles after entering RESP, err_o=1 and held. A later mem_rvalid_i produces no rvalid.
- Reset in REQ: rst_ni low while mem_req_o=1. Required: mem_req_o=0 immediately, no rvalid. After release, a new fetch completes in 3 cycles.
